// File: rtl/microstore_sequencer_if.sv
// Microstore word, encoder and status bundle between the microstore side and the sequencer.
// The sequencer drives only the registered state and status fields; everything else comes from the word and the encoder.
interface microstore_sequencer_if #(
    parameter int STATE_W = 7
);
    logic [2:0]         ns_sel;
    logic [STATE_W-1:0] n_field;
    logic               inv;
    logic               cond;
    logic               moc;
    logic [STATE_W-1:0] decode_state;
    logic               decode_valid;
    logic [STATE_W-1:0] current_state;
    logic [2:0]         stack_depth;
    logic               timeout_err;
    logic               stack_err;
    logic               illegal_op;

    modport master (
        output ns_sel, n_field, inv, cond, moc, decode_state, decode_valid,
        input  current_state, stack_depth, timeout_err, stack_err, illegal_op
    );

    modport slave (
        input  ns_sel, n_field, inv, cond, moc, decode_state, decode_valid,
        output current_state, stack_depth, timeout_err, stack_err, illegal_op
    );
endinterface

// File: rtl/microstore_sequencer.sv
// Microprogram next-state sequencer with a return stack and MOC wait timeout.
// One-cycle registered update of the state; no backpressure, WAIT holds the state until MOC.
module microstore_sequencer #(
    parameter int STATE_W     = 7,
    parameter int STACK_DEPTH = 4,
    parameter int MOC_TIMEOUT = 16,
    parameter int FETCH_STATE = 0,
    parameter int FAULT_STATE = 5
) (
    input logic                   clk,
    input logic                   reset,
    microstore_sequencer_if.slave seq
);
    localparam int DEPTH_W = 3;
    localparam int CNT_W   = $clog2(MOC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        SEL_ENCODE  = 3'd0,
        SEL_JUMP    = 3'd1,
        SEL_INCR    = 3'd2,
        SEL_COND    = 3'd3,
        SEL_WAIT    = 3'd4,
        SEL_CALL    = 3'd5,
        SEL_RETURN  = 3'd6,
        SEL_RESTART = 3'd7
    } sel_e;

    sel_e               sel;
    logic [STATE_W-1:0] state_q, state_d, incr, top;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               terr_q, terr_d, serr_q, serr_d, iop_q, iop_d;
    logic               do_push;
    logic [STATE_W-1:0] stack_mem [STACK_DEPTH];

    assign sel     = sel_e'(seq.ns_sel);
    assign incr    = state_q + STATE_W'(1);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = incr;
        depth_d = depth_q;
        cnt_d   = '0;
        terr_d  = terr_q;
        serr_d  = serr_q;
        iop_d   = iop_q;
        do_push = 1'b0;
        top     = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) top = stack_mem[i];
        end
        unique case (sel)
            SEL_ENCODE: begin
                if (seq.decode_valid) begin
                    state_d = seq.decode_state;
                end else begin
                    state_d = STATE_W'(FAULT_STATE);
                    iop_d   = 1'b1;
                end
            end
            SEL_JUMP: state_d = seq.n_field;
            SEL_INCR: state_d = incr;
            SEL_COND: state_d = (seq.cond ^ seq.inv) ? seq.n_field : incr;
            SEL_WAIT: begin
                // Counter counts stalled cycles only; the completing cycle costs nothing extra.
                if (seq.moc ^ seq.inv) begin
                    state_d = incr;
                end else if (cnt_inc == CNT_W'(MOC_TIMEOUT)) begin
                    state_d = STATE_W'(FAULT_STATE);
                    terr_d  = 1'b1;
                end else begin
                    state_d = state_q;
                    cnt_d   = cnt_inc;
                end
            end
            SEL_CALL: begin
                if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                    state_d = STATE_W'(FAULT_STATE);
                    serr_d  = 1'b1;
                end else begin
                    state_d = seq.n_field;
                    depth_d = depth_q + DEPTH_W'(1);
                    do_push = 1'b1;
                end
            end
            SEL_RETURN: begin
                if (depth_q == '0) begin
                    state_d = STATE_W'(FAULT_STATE);
                    serr_d  = 1'b1;
                end else begin
                    state_d = top;
                    depth_d = depth_q - DEPTH_W'(1);
                end
            end
            SEL_RESTART: begin
                state_d = STATE_W'(FETCH_STATE);
                depth_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_W'(FETCH_STATE);
            depth_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            serr_q  <= 1'b0;
            iop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            serr_q  <= serr_d;
            iop_q   <= iop_d;
        end
    end

    // Entries above depth are dead, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!reset && do_push && depth_q == DEPTH_W'(i)) stack_mem[i] <= incr;
        end
    end

    assign seq.current_state = state_q;
    assign seq.stack_depth   = depth_q;
    assign seq.timeout_err   = terr_q;
    assign seq.stack_err     = serr_q;
    assign seq.illegal_op    = iop_q;
endmodule

// File: doc/microstore_sequencer.md
Name: microstore_sequencer

Overview:
- Next-state controller for the microprogrammed control unit.
- Holds the 7-bit current microstate, which addresses the microstore directly.
- Computes the next state each cycle from:
  - a 3-bit next-state select field and a 7-bit N (target) field supplied by the microstore word;
  - condition and memory-complete (MOC) inputs;
  - the instruction encoder's start state.
- Adds a small microsubroutine stack and MOC wait-timeout fault detection.

Parameters:
- STATE_W, 7, width of microstate address.
- STACK_DEPTH, 4, microsubroutine return-stack entries (power of 2).
- MOC_TIMEOUT, 16, max consecutive WAIT cycles before fault.
- FETCH_STATE, 0, state entered after reset and on select RESTART.
- FAULT_STATE, 5, state entered on illegal opcode, timeout, or stack error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high.
- ns_sel  in  3  next-state select, from microstore word
- n_field  in  STATE_W  target state, from microstore word
- inv  in  1  invert cond (COND) / invert moc (WAIT)
- cond  in  1  datapath condition (ALU flag / branch test)
- moc  in  1  memory operation complete
- decode_state  in  STATE_W  start state of the current instruction, from the encoder
- decode_valid  in  1  encoder recognised the opcode/funct
- current_state  out  STATE_W  registered microstate, drives the microstore address
- stack_depth  out  3  number of valid return entries (0..STACK_DEPTH)
- timeout_err  out  1  sticky, MOC timeout occurred
- stack_err  out  1  sticky, push when full or pop when empty
- illegal_op  out  1  sticky, ENCODE with decode_valid=0

Behaviour:
- Reset (any cycle, including mid-WAIT or mid-subroutine), takes effect at the next edge:
  - current_state=FETCH_STATE;
  - stack emptied, stack_depth=0;
  - wait counter=0;
  - all sticky flags=0.
- Otherwise current_state updates once per rising edge; the next state is a pure function of the current inputs and state.
- All addition is modulo 2^STATE_W; incr = current_state+1, so 127 -> 0.
- ns_sel decode:
  - 0 ENCODE: decode_valid ? decode_state : FAULT_STATE, and illegal_op set.
  - 1 JUMP: n_field.
  - 2 INCR: incr.
  - 3 COND: (cond^inv) ? n_field : incr.
  - 4 WAIT:
    - (moc^inv)=1: incr, wait counter cleared.
    - Otherwise: hold current_state and increment the wait counter.
    - When the counter would reach MOC_TIMEOUT: next = FAULT_STATE, timeout_err set, counter cleared.
  - 5 CALL: push incr, next = n_field. If stack full: no push, next = FAULT_STATE, stack_err set.
  - 6 RETURN: pop, next = popped value. If stack empty: next = FAULT_STATE, stack_err set.
  - 7 RESTART: FETCH_STATE; stack emptied (exception/abort path).
- Wait counter:
  - Cleared whenever the state leaves WAIT (any ns_sel != 4).
  - Counts only consecutive non-complete WAIT cycles.
- A WAIT with moc=1 on its first cycle costs exactly 1 cycle (no added latency).
- Stack:
  - LIFO; push and pop never occur in the same cycle.
  - stack_depth changes on the same edge as current_state.
- Sticky flags clear only on reset. Entering FAULT_STATE does not clear the flags or the stack.
- No combinational path from inputs to current_state (registered output).

Test Plan:
- Reset and fetch:
  - Stimulus: hold reset 2 cycles, then ns_sel=2 for 3 cycles.
  - Required: current_state 0 -> 1 -> 2 -> 3; flags 0; stack_depth 0.
- Encode and cond:
  - Stimulus: state 2, ns_sel=0, decode_state=7'd16, decode_valid=1; then ns_sel=3, n_field=7'd30, cond=1, inv=1.
  - Required: 16, then 17 (inverted condition false).
  - Repeat with inv=0 -> 30.
- Illegal opcode:
  - Stimulus: ns_sel=0, decode_valid=0.
  - Required: next state 5, illegal_op=1, stays 1 across later cycles.
- MOC wait:
  - Stimulus: state 9, ns_sel=4, inv=0, moc low 3 cycles then high.
  - Required: state 9 held 3 cycles, then 10.
  - Stimulus: moc never high.
  - Required: after 16 cycles state=5, timeout_err=1.
  - Stimulus: reset asserted mid-wait.
  - Required: state 0, counter cleared.
- Call/return:
  - Stimulus: at state 12, CALL n_field=40; at 40, CALL n_field=50; at 50, RETURN; then RETURN.
  - Required: 40 (depth 1), 50 (depth 2), 41 (depth 1), 13 (depth 0).
- Stack errors:
  - Stimulus: 5 consecutive CALLs.
  - Required: fifth goes to state 5, stack_err=1, depth stays 4.
  - Stimulus: RETURN from reset.
  - Required: state 5, stack_err=1.
  - Stimulus: state 127, ns_sel=2.
  - Required: wraps to 0.
